// File: rtl/line_buff_fill.sv
// Line buffer fill engine: copies one tile row from the frame memory into
// line buffer A or B on request, then pulses done and steps to the next row.
module line_buff_fill #(
  parameter int unsigned TILE_PER_LINE  = 160,
  parameter int unsigned TILE_PER_COL   = 120,
  parameter int unsigned DATA_WIDTH     = 12,
  parameter int unsigned TILE_CTR_WIDTH = $clog2(TILE_PER_LINE),
  parameter int unsigned ROW_CTR_WIDTH  = $clog2(TILE_PER_COL),
  parameter int unsigned MEM_ADDR_WIDTH = $clog2(TILE_PER_LINE * TILE_PER_COL)
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic [1:0]                buff_fill_req_i,
  output logic                      mem_rd_en_o,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [DATA_WIDTH-1:0]     mem_rd_data_i,
  output logic [1:0]                buff_wr_en_o,
  output logic [TILE_CTR_WIDTH-1:0] buff_wr_addr_o,
  output logic [DATA_WIDTH-1:0]     buff_wr_data_o,
  output logic [1:0]                buff_fill_done_o,
  output logic                      busy_o,
  output logic                      req_err_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [TILE_CTR_WIDTH-1:0] LAST_IDX    = TILE_CTR_WIDTH'(TILE_PER_LINE - 1);
  localparam logic [ROW_CTR_WIDTH-1:0]  LAST_ROW    = ROW_CTR_WIDTH'(TILE_PER_COL - 1);
  localparam logic [MEM_ADDR_WIDTH-1:0] LINE_STRIDE = MEM_ADDR_WIDTH'(TILE_PER_LINE);

  logic [1:0]                state_q,   state_d;
  logic [TILE_CTR_WIDTH-1:0] idx_q,     idx_d;
  logic [ROW_CTR_WIDTH-1:0]  row_q,     row_d;
  logic [MEM_ADDR_WIDTH-1:0] base_q,    base_d;
  logic [1:0]                tgt_q,     tgt_d;
  logic                      rd_en_q,   rd_en_d;
  logic [MEM_ADDR_WIDTH-1:0] addr_q,    addr_d;
  logic [1:0]                wr_en_q,   wr_en_d;
  logic [TILE_CTR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]     wr_data_q, wr_data_d;
  logic [1:0]                done_q,    done_d;
  logic                      busy_q,    busy_d;
  logic                      err_q,     err_d;

  logic req_valid_c;
  logic req_any_c;

  assign req_valid_c = (buff_fill_req_i == 2'b01) || (buff_fill_req_i == 2'b10);
  assign req_any_c   = |buff_fill_req_i;

  // Next state, read issue, write pipeline and row advance
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    row_d     = row_q;
    base_d    = base_q;
    tgt_d     = tgt_q;
    rd_en_d   = 1'b0;
    addr_d    = addr_q;
    done_d    = 2'b00;
    busy_d    = 1'b0;
    err_d     = err_q;
    // Memory data for the read issued last cycle is captured alongside its index.
    wr_en_d   = rd_en_q ? tgt_q : 2'b00;
    wr_addr_d = rd_en_q ? idx_q : '0;
    wr_data_d = rd_en_q ? mem_rd_data_i : '0;

    case (state_q)
      IDLE: begin
        if (req_valid_c) begin
          state_d = READ;
          tgt_d   = buff_fill_req_i;
          idx_d   = '0;
          rd_en_d = 1'b1;
          addr_d  = base_q;
          busy_d  = 1'b1;
        end else if (req_any_c) begin
          err_d = 1'b1;
        end
      end
      READ: begin
        if (req_any_c) err_d = 1'b1;
        busy_d = 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = DRAIN;
        end else begin
          idx_d   = idx_q + TILE_CTR_WIDTH'(1);
          rd_en_d = 1'b1;
          addr_d  = base_q + MEM_ADDR_WIDTH'(idx_d);
        end
      end
      DRAIN: begin
        if (req_any_c) err_d = 1'b1;
        state_d = DONE;
        done_d  = tgt_q;
      end
      DONE: begin
        if (req_any_c) err_d = 1'b1;
        state_d = IDLE;
        idx_d   = '0;
        if (row_q == LAST_ROW) begin
          row_d  = '0;
          base_d = '0;
        end else begin
          row_d  = row_q + ROW_CTR_WIDTH'(1);
          base_d = base_q + LINE_STRIDE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs, synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      row_q     <= '0;
      base_q    <= '0;
      tgt_q     <= 2'b00;
      rd_en_q   <= 1'b0;
      addr_q    <= '0;
      wr_en_q   <= 2'b00;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 2'b00;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      row_q     <= row_d;
      base_q    <= base_d;
      tgt_q     <= tgt_d;
      rd_en_q   <= rd_en_d;
      addr_q    <= addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  assign mem_rd_en_o      = rd_en_q;
  assign mem_addr_o       = addr_q;
  assign buff_wr_en_o     = wr_en_q;
  assign buff_wr_addr_o   = wr_addr_q;
  assign buff_wr_data_o   = wr_data_q;
  assign buff_fill_done_o = done_q;
  assign busy_o           = busy_q;
  assign req_err_o        = err_q;

endmodule

// File: tb/tb_line_buff_fill.sv
// Directed bench for line_buff_fill: full-frame fill sequence, wrap, dropped
// requests and reset mid-fill, checked cycle by cycle against expected timing.
module tb_line_buff_fill;

  localparam int unsigned TPL = 160;
  localparam int unsigned TPC = 120;
  localparam int unsigned DW  = 12;
  localparam int unsigned TCW = $clog2(TPL);
  localparam int unsigned MAW = $clog2(TPL * TPC);
  localparam int          LAT = TPL + 2;

  logic           clk;
  logic           rstn;
  logic [1:0]     req;
  logic           mem_rd_en;
  logic [MAW-1:0] mem_addr;
  logic [DW-1:0]  mem_rd_data;
  logic [1:0]     wr_en;
  logic [TCW-1:0] wr_addr;
  logic [DW-1:0]  wr_data;
  logic [1:0]     done;
  logic           busy;
  logic           err;

  int n_chk;
  int n_err;
  logic err_exp;

  line_buff_fill dut (
    .clk_i            (clk),
    .rstn_i           (rstn),
    .buff_fill_req_i  (req),
    .mem_rd_en_o      (mem_rd_en),
    .mem_addr_o       (mem_addr),
    .mem_rd_data_i    (mem_rd_data),
    .buff_wr_en_o     (wr_en),
    .buff_wr_addr_o   (wr_addr),
    .buff_wr_data_o   (wr_data),
    .buff_fill_done_o (done),
    .busy_o           (busy),
    .req_err_o        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame memory contents: an address-dependent pattern so misplaced words show up
  function automatic logic [DW-1:0] mem_word(input int a);
    return DW'(a * 37 + 5);
  endfunction

  // Frame memory: the word for the presented read address is ready by the capturing edge
  assign mem_rd_data = mem_rd_en ? mem_word(int'(mem_addr)) : '0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_en"},   32'(mem_rd_en), 32'd0);
    chk({tag, "_addr"},    32'(mem_addr),  32'd0);
    chk({tag, "_wr_en"},   32'(wr_en),     32'd0);
    chk({tag, "_wr_addr"}, 32'(wr_addr),   32'd0);
    chk({tag, "_wr_data"}, 32'(wr_data),   32'd0);
    chk({tag, "_done"},    32'(done),      32'd0);
    chk({tag, "_busy"},    32'(busy),      32'd0);
    chk({tag, "_err"},     32'(err),       32'd0);
  endtask

  // One fill: request sampled at edge k, cycle c of the loop is cycle k+c.
  // Optionally injects a stray request at cycle inj_c, or resets at cycle rst_c.
  task automatic do_fill(input logic [1:0] tgt, input int base,
                         input int inj_c, input logic [1:0] inj_req, input int rst_c);
    @(negedge clk);
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    req = tgt;
    for (int c = 1; c <= LAT; c++) begin
      @(negedge clk);
      req = (c == inj_c) ? inj_req : 2'b00;
      if (c == inj_c) err_exp = 1'b1;
      chk("rd_en", 32'(mem_rd_en), (c <= TPL) ? 32'd1 : 32'd0);
      if (c <= TPL) chk("rd_addr", 32'(mem_addr), 32'(base + c - 1));
      chk("wr_en", 32'(wr_en), (c >= 2 && c <= TPL + 1) ? 32'(tgt) : 32'd0);
      if (c >= 2 && c <= TPL + 1) begin
        chk("wr_addr", 32'(wr_addr), 32'(c - 2));
        chk("wr_data", 32'(wr_data), 32'(mem_word(base + c - 2)));
      end
      chk("done", 32'(done), (c == LAT) ? 32'(tgt) : 32'd0);
      chk("busy", 32'(busy), (c <= TPL + 1) ? 32'd1 : 32'd0);
      if (c == rst_c) begin
        rstn = 1'b0;
        @(negedge clk);
        chk_all_zero("rst_mid");
        rstn = 1'b1;
        err_exp = 1'b0;
        for (int j = 0; j < LAT + 8; j++) begin
          @(negedge clk);
          chk("post_rst_done",  32'(done),      32'd0);
          chk("post_rst_wr_en", 32'(wr_en),     32'd0);
          chk("post_rst_rd_en", 32'(mem_rd_en), 32'd0);
        end
        return;
      end
    end
    chk("err_after_fill", 32'(err), 32'(err_exp));
  endtask

  initial begin
    n_chk   = 0;
    n_err   = 0;
    err_exp = 1'b0;
    req     = 2'b00;
    rstn    = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rstn = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_rd_en", 32'(mem_rd_en), 32'd0);

    // A full frame of fills alternating A/B, with the dropped-request cases mixed in
    for (int r = 0; r < int'(TPC); r++) begin
      if (r == 2) begin
        @(negedge clk);
        req = 2'b11;
        @(negedge clk);
        req = 2'b00;
        err_exp = 1'b1;
        chk("bad_req_busy",  32'(busy),      32'd0);
        chk("bad_req_rd_en", 32'(mem_rd_en), 32'd0);
        chk("bad_req_err",   32'(err),       32'd1);
        @(negedge clk);
        chk("bad_req_rd_en2", 32'(mem_rd_en), 32'd0);
        chk("bad_req_busy2",  32'(busy),      32'd0);
      end
      do_fill((r % 2 == 0) ? 2'b01 : 2'b10, r * int'(TPL),
              (r == 2) ? 50 : 0, 2'b10, 0);
    end

    // Wrap back to row 0
    do_fill(2'b10, 0, 0, 2'b00, 0);

    // Row 1 fill aborted by reset at tile 50; the next fill restarts at row 0
    do_fill(2'b01, int'(TPL), 0, 2'b00, 51);
    do_fill(2'b01, 0, 0, 2'b00, 0);
    chk("final_err", 32'(err), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
